// File: rtl/arbitro_multiplexador.sv
// Round-robin arbiter for the shared 4:1 byte multiplexer of the Nrisc datapath.
// Each grant is capped at MAX_CICLOS transfers; releases regrant on the same edge.
module arbitro_multiplexador #(
  parameter int unsigned MAX_CICLOS = 4,
  parameter int unsigned LARGURA    = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [3:0]         pedido,
  input  logic [LARGURA-1:0] entrada1,
  input  logic [LARGURA-1:0] entrada2,
  input  logic [LARGURA-1:0] entrada3,
  input  logic [LARGURA-1:0] entrada4,
  output logic [3:0]         concessao,
  output logic [1:0]         selecao,
  output logic [LARGURA-1:0] saida,
  output logic               valido,
  output logic               ocupado
);

  localparam int unsigned CW     = 4;
  localparam logic [CW-1:0] LIMITE = CW'(MAX_CICLOS - 1);

  typedef enum logic {OCIOSO, CONCEDIDO} estado_t;

  estado_t            estado, estado_n;
  logic [1:0]         ultimo, ultimo_n;
  logic [CW-1:0]      contador, contador_n;
  logic [3:0]         concessao_n;
  logic [1:0]         selecao_n;
  logic [LARGURA-1:0] saida_n;
  logic               valido_n;
  logic               ocupado_n;

  logic [LARGURA-1:0] dado_sel_c;
  logic               transf_c;
  logic [3:0]         pedido_lib_c;
  logic [2:0]         arb_ocioso_c;
  logic [2:0]         arb_lib_c;

  // Returns {found, index}; search starts after ult and wraps, ult itself last.
  function automatic logic [2:0] arbitra(input logic [3:0] req, input logic [1:0] ult);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = 2'(ult + 2'(k));
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // Datapath multiplexer encoding: 00->entrada1 .. 11->entrada4
  always_comb begin
    dado_sel_c = entrada1;
    case (selecao)
      2'd0: dado_sel_c = entrada1;
      2'd1: dado_sel_c = entrada2;
      2'd2: dado_sel_c = entrada3;
      2'd3: dado_sel_c = entrada4;
      default: dado_sel_c = entrada1;
    endcase
  end

  assign transf_c     = pedido[selecao];
  // A requester that dropped its request is excluded from the regrant.
  assign pedido_lib_c = transf_c ? pedido : (pedido & ~(4'b0001 << selecao));
  assign arb_ocioso_c = arbitra(pedido, ultimo);
  assign arb_lib_c    = arbitra(pedido_lib_c, selecao);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      ultimo    <= 2'd3;
      contador  <= '0;
      concessao <= 4'b0000;
      selecao   <= 2'd0;
      saida     <= '0;
      valido    <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      estado    <= estado_n;
      ultimo    <= ultimo_n;
      contador  <= contador_n;
      concessao <= concessao_n;
      selecao   <= selecao_n;
      saida     <= saida_n;
      valido    <= valido_n;
      ocupado   <= ocupado_n;
    end
  end

  always_comb begin
    estado_n    = estado;
    ultimo_n    = ultimo;
    contador_n  = contador;
    concessao_n = concessao;
    selecao_n   = selecao;
    saida_n     = saida;
    valido_n    = 1'b0;
    ocupado_n   = ocupado;

    case (estado)
      OCIOSO: begin
        concessao_n = 4'b0000;
        ocupado_n   = 1'b0;
        contador_n  = '0;
        if (arb_ocioso_c[2]) begin
          concessao_n = 4'b0001 << arb_ocioso_c[1:0];
          selecao_n   = arb_ocioso_c[1:0];
          ocupado_n   = 1'b1;
          estado_n    = CONCEDIDO;
        end
      end
      CONCEDIDO: begin
        if (transf_c) begin
          saida_n    = dado_sel_c;
          valido_n   = 1'b1;
          contador_n = contador + CW'(1);
        end
        // Release on dropped request or after the last allowed transfer.
        if (!transf_c || contador == LIMITE) begin
          ultimo_n   = selecao;
          contador_n = '0;
          if (arb_lib_c[2]) begin
            concessao_n = 4'b0001 << arb_lib_c[1:0];
            selecao_n   = arb_lib_c[1:0];
            ocupado_n   = 1'b1;
          end else begin
            concessao_n = 4'b0000;
            ocupado_n   = 1'b0;
            estado_n    = OCIOSO;
          end
        end
      end
      default: estado_n = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_arbitro_multiplexador.sv
// Bench for arbitro_multiplexador: directed scenarios plus random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_arbitro_multiplexador;

  localparam int MAXC = 4;

  logic       clock;
  logic       reset_n;
  logic [3:0] pedido;
  logic [7:0] entrada1, entrada2, entrada3, entrada4;
  logic [3:0] concessao;
  logic [1:0] selecao;
  logic [7:0] saida;
  logic       valido;
  logic       ocupado;

  int checks;
  int failures;

  arbitro_multiplexador #(.MAX_CICLOS(MAXC), .LARGURA(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .pedido   (pedido),
    .entrada1 (entrada1),
    .entrada2 (entrada2),
    .entrada3 (entrada3),
    .entrada4 (entrada4),
    .concessao(concessao),
    .selecao  (selecao),
    .saida    (saida),
    .valido   (valido),
    .ocupado  (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: who owns the mux, how many transfers it has used, who went last.
  int         m_owner;
  int         m_used;
  int         m_last;
  logic [3:0] m_conc;
  logic [1:0] m_sel;
  logic [7:0] m_out;
  logic       m_val;
  logic       m_busy;

  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    logic [7:0] din [4];
    logic [3:0] cands;
    logic       did;
    if (!reset_n) begin
      m_owner = -1; m_used = 0; m_last = 3;
      m_conc = 4'b0000; m_sel = 2'd0; m_out = 8'h00; m_val = 1'b0; m_busy = 1'b0;
    end else begin
      din[0] = entrada1; din[1] = entrada2; din[2] = entrada3; din[3] = entrada4;
      if (m_owner < 0) begin
        m_val   = 1'b0;
        m_owner = rr_pick(m_last, pedido);
        m_used  = 0;
      end else begin
        did = pedido[m_owner];
        if (did) begin
          m_out = din[m_owner];
          m_val = 1'b1;
          m_used++;
        end else begin
          m_val = 1'b0;
        end
        if (!did || m_used == MAXC) begin
          m_last = m_owner;
          cands  = pedido;
          if (!did) cands[m_owner] = 1'b0;
          m_owner = rr_pick(m_last, cands);
          m_used  = 0;
        end
      end
      m_busy = (m_owner >= 0);
      m_conc = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      if (m_busy) m_sel = 2'(m_owner);
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("concessao", int'(concessao), int'(m_conc));
      chk("selecao",   int'(selecao),   int'(m_sel));
      chk("valido",    int'(valido),    int'(m_val));
      chk("ocupado",   int'(ocupado),   int'(m_busy));
      if (m_val) chk("saida", int'(saida), int'(m_out));
    end
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_concessao"}, int'(concessao), 0);
    chk({tag, "_valido"},    int'(valido),    0);
    chk({tag, "_saida"},     int'(saida),     0);
    chk({tag, "_ocupado"},   int'(ocupado),   0);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; pedido = 4'b0000;
    entrada1 = 8'h00; entrada2 = 8'h00; entrada3 = 8'h00; entrada4 = 8'h00;
    @(negedge clock);
    chk_zero("reset");
    chk("reset_selecao", int'(selecao), 0);
    reset_n = 1'b1;

    // Reset mid-burst: requester 1 granted, two transfers, async reset between edges
    pedido = 4'b0010; entrada2 = 8'h22;
    cyc();
    chk("rst_grant", int'(concessao), 4'b0010);
    cyc(); cyc();
    chk("rst_burst_valido", int'(valido), 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    #1 reset_n = 1'b1;
    pedido = 4'b1111;
    entrada1 = 8'h10; entrada2 = 8'h20; entrada3 = 8'h30; entrada4 = 8'h40;
    cyc();
    chk("contention_first", int'(concessao), 4'b0001);
    // Full contention: grants 0,1,2,3,0 with four transfers each
    for (int t = 0; t < 20; t++) begin
      cyc();
      chk("contention_valido", int'(valido), 1);
      chk("contention_saida", int'(saida), 16 * ((t / 4) % 4 + 1));
    end
    pedido = 4'b0000;
    cyc(); cyc();

    // Single request
    pedido = 4'b0010; entrada2 = 8'h5A;
    cyc();
    chk("single_grant", int'(concessao), 4'b0010);
    chk("single_sel", int'(selecao), 1);
    cyc();
    chk("single_t1", int'(saida), 8'h5A);
    cyc();
    chk("single_t2", int'(valido), 1);
    pedido = 4'b0000;
    cyc();
    chk("single_end_valido", int'(valido), 0);
    chk("single_end_grant", int'(concessao), 0);
    cyc();

    // Lone requester across the burst limit: no gap
    pedido = 4'b0100; entrada3 = 8'h33;
    cyc();
    for (int t = 0; t < 10; t++) begin
      cyc();
      chk("lone_valido", int'(valido), 1);
      chk("lone_grant", int'(concessao), 4'b0100);
    end
    pedido = 4'b0000;
    cyc(); cyc();

    // Early drop with handoff, then wrap-around priority
    pedido = 4'b0001; entrada1 = 8'h11; entrada4 = 8'h44;
    cyc();
    chk("drop_grant0", int'(concessao), 4'b0001);
    cyc();
    chk("drop_t0", int'(saida), 8'h11);
    pedido = 4'b1000;
    cyc();
    chk("handoff_valido", int'(valido), 0);
    chk("handoff_grant", int'(concessao), 4'b1000);
    cyc();
    chk("handoff_saida", int'(saida), 8'h44);
    cyc(); cyc();
    pedido = 4'b1001;
    cyc();
    chk("wrap_last_t", int'(valido), 1);
    chk("wrap_grant", int'(concessao), 4'b0001);
    pedido = 4'b0000;
    cyc(); cyc();

    // Random traffic with occasional asynchronous resets
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) pedido = 4'($urandom_range(0, 15));
      entrada1 = 8'($urandom); entrada2 = 8'($urandom);
      entrada3 = 8'($urandom); entrada4 = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset_n = 1'b0;
        #1 chk_zero("rand_reset");
        #1 reset_n = 1'b1;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
